// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the single-issue MIPS pipeline.
//
// It owns the program counter, which drives the combinational instruction
// memory. The word that comes back is registered into the IF/ID pipeline
// register together with PC+4. The block also handles stall, flush, the
// branch/jump redirect and a sticky halt on an illegal fetch address.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | normal fetch; next_pc is computed and range-checked every edge
// HALT  | illegal fetch seen; everything frozen until rst
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   stall           hold PC and IF/ID
//   flush           bubble IF/ID on this edge
//   branch_taken    EX-resolved taken branch to branch_target
//   jump            ID-resolved jump to jump_target
//   instr_in        word returned by instruction memory for pc_out
//   pc_out          current PC (byte address) to instruction memory
//   ifid_instr      registered instruction
//   ifid_pc_plus4   registered PC+4 of that instruction
//   ifid_valid      IF/ID holds a real instruction
//   fetch_fault     sticky illegal-fetch flag
//   fetch_count     instructions accepted into IF/ID (wraps)
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 100,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    state_t      state;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        redirect;
    logic        illegal;

    // Modulo-2^32 increment; a wrap to 0 is only caught if 0 is out of range.
    assign pc_plus4 = pc_out + 32'd4;
    assign redirect = branch_taken | jump;

    always_comb begin
        next_pc = pc_plus4;
        if (branch_taken)
            next_pc = branch_target;
        else if (jump)
            next_pc = jump_target;
        else if (stall)
            next_pc = pc_out;
    end

    assign illegal = (next_pc[1:0] != 2'b00) ||
                     ({2'b00, next_pc[31:2]} >= IMEM_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            pc_out        <= RESET_PC;
            ifid_instr    <= NOP_WORD;
            ifid_pc_plus4 <= 32'd0;
            ifid_valid    <= 1'b0;
            fetch_fault   <= 1'b0;
            fetch_count   <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (illegal) begin
                        // PC keeps the last good address for post-mortem.
                        state       <= HALT;
                        fetch_fault <= 1'b1;
                        ifid_instr  <= NOP_WORD;
                        ifid_valid  <= 1'b0;
                    end else begin
                        pc_out <= next_pc;
                        // The word fetched this cycle is wrong-path on a
                        // redirect, so a redirect also bubbles IF/ID.
                        if (redirect || flush) begin
                            ifid_instr <= NOP_WORD;
                            ifid_valid <= 1'b0;
                        end else if (!stall) begin
                            ifid_instr    <= instr_in;
                            ifid_pc_plus4 <= pc_plus4;
                            ifid_valid    <= 1'b1;
                            fetch_count   <= fetch_count + 32'd1;
                        end
                    end
                end
                HALT: begin
                    ifid_instr <= NOP_WORD;
                    ifid_valid <= 1'b0;
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int IMEM_WORDS = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out, ifid_instr, ifid_pc_plus4, fetch_count;
    logic        ifid_valid, fetch_fault;

    logic [31:0] mem [0:IMEM_WORDS-1];

    int checks = 0;
    int errors = 0;

    // bench model state
    logic [31:0] exp_pc, exp_instr, exp_count;
    logic        exp_valid, exp_fault, exp_halt;
    logic [63:0] sb_q[$];

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(IMEM_WORDS),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .instr_in     (instr_in),
        .pc_out       (pc_out),
        .ifid_instr   (ifid_instr),
        .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_valid   (ifid_valid),
        .fetch_fault  (fetch_fault),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (pc_out[31:2] < 30'(IMEM_WORDS))
            instr_in = mem[pc_out[31:2]];
        else
            instr_in = 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_target = 0;
    endtask

    task automatic model_reset();
        exp_pc = 0; exp_instr = 0; exp_count = 0;
        exp_valid = 0; exp_fault = 0; exp_halt = 0;
        sb_q.delete();
    endtask

    // Advance one edge with the inputs currently driven; the model predicts
    // the outcome and pushes the expected IF/ID load into the scoreboard.
    task automatic step();
        logic [31:0] nxt;
        logic        bad;
        logic        pushed;
        logic [63:0] item;
        pushed = 0;
        if (branch_taken)      nxt = branch_target;
        else if (jump)         nxt = jump_target;
        else if (stall)        nxt = exp_pc;
        else                   nxt = exp_pc + 32'd4;
        bad = (nxt[1:0] != 2'b00) || ((nxt >> 2) >= 32'(IMEM_WORDS));
        if (exp_halt) begin
            exp_valid = 0; exp_instr = 0;
        end else if (bad) begin
            exp_halt = 1; exp_fault = 1; exp_valid = 0; exp_instr = 0;
        end else begin
            if (branch_taken || jump || flush) begin
                exp_valid = 0; exp_instr = 0;
            end else if (!stall) begin
                sb_q.push_back({mem[exp_pc >> 2], exp_pc + 32'd4});
                exp_instr = mem[exp_pc >> 2];
                exp_valid = 1;
                exp_count = exp_count + 1;
                pushed = 1;
            end
            exp_pc = nxt;
        end
        @(posedge clk);
        #1;
        chk("pc_out", pc_out, exp_pc);
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, exp_valid});
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, exp_fault});
        chk("fetch_count", fetch_count, exp_count);
        chk("ifid_instr", ifid_instr, exp_instr);
        if (pushed) begin
            item = sb_q.pop_front();
            chk("sb_instr", ifid_instr, item[63:32]);
            chk("sb_pc_plus4", ifid_pc_plus4, item[31:0]);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        idle_inputs();
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pp4", ifid_pc_plus4, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        rst = 0;

        // free run to pc 8, then stall two cycles, then release
        step(); step();
        chk("run_pc8", pc_out, 32'd8);
        chk("run_instr22", ifid_instr, 32'h22);
        stall = 1;
        step(); step();
        chk("stall_pc", pc_out, 32'd8);
        chk("stall_instr", ifid_instr, 32'h22);
        chk("stall_pp4", ifid_pc_plus4, 32'd8);
        chk("stall_count", fetch_count, 32'd2);
        stall = 0;
        step();
        chk("rel_instr", ifid_instr, 32'h33);
        chk("rel_pp4", ifid_pc_plus4, 32'd12);
        chk("rel_pc", pc_out, 32'd12);
        chk("rel_count", fetch_count, 32'd3);

        // branch with stall in the same cycle
        branch_taken = 1; branch_target = 32'h40; stall = 1;
        step();
        chk("br_pc", pc_out, 32'h40);
        chk("br_valid", {31'd0, ifid_valid}, 32'd0);
        idle_inputs();
        step();
        chk("br_tgt_instr", ifid_instr, mem[16]);
        chk("br_tgt_pp4", ifid_pc_plus4, 32'h44);

        // branch beats jump
        jump = 1; jump_target = 32'h20; branch_taken = 1; branch_target = 32'h30;
        step();
        chk("prio_pc", pc_out, 32'h30);
        idle_inputs();
        step();
        chk("prio_pp4", ifid_pc_plus4, 32'h34);
        chk("prio_count", fetch_count, 32'd5);

        // asynchronous reset between edges
        #3;
        rst = 1;
        #1;
        chk("arst_pc", pc_out, 32'h0);
        chk("arst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("arst_count", fetch_count, 32'd0);
        chk("arst_instr", ifid_instr, 32'h0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        step();
        chk("restart_instr", ifid_instr, 32'h11);
        chk("restart_pp4", ifid_pc_plus4, 32'd4);

        // flush alone advances PC; flush with stall holds PC
        flush = 1;
        step();
        stall = 1;
        step();
        idle_inputs();
        step();

        // random legal traffic
        for (int n = 0; n < 40; n++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            jump = ($urandom_range(0, 7) == 0);
            branch_target = 32'($urandom_range(0, IMEM_WORDS - 2)) << 2;
            jump_target = 32'($urandom_range(0, IMEM_WORDS - 2)) << 2;
            step();
        end
        idle_inputs();

        // misaligned jump target faults; halt survives any inputs
        step();
        jump = 1; jump_target = 32'h192;
        step();
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        for (int n = 0; n < 10; n++) begin
            stall = $urandom_range(0, 1);
            flush = $urandom_range(0, 1);
            branch_taken = $urandom_range(0, 1);
            jump = $urandom_range(0, 1);
            branch_target = 32'($urandom_range(0, 20)) << 2;
            jump_target = 32'($urandom_range(0, 20)) << 2;
            step();
        end
        idle_inputs();
        do_reset();
        chk("clr_fault", {31'd0, fetch_fault}, 32'd0);
        step();

        // word index 100 is one past the end
        jump = 1; jump_target = 32'h190;
        step();
        chk("oor_fault", {31'd0, fetch_fault}, 32'd1);
        chk("oor_pc", pc_out, 32'd4);
        idle_inputs();
        step();
        do_reset();
        chk("final_fault", {31'd0, fetch_fault}, 32'd0);
        chk("final_pc", pc_out, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the single-issue MIPS pipeline. It sits directly upstream of the combinational instruction memory.
- Owns the program counter and drives it to the memory's PC input. Takes the returned 32-bit Instr back in the same cycle.
- Registers the fetched word and PC+4 into the IF/ID pipeline register for decode.
- Handles stall, flush, branch/jump redirect, and a halt-on-bad-fetch fault state.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 100, number of 32-bit words in instruction memory; legal word index 0..IMEM_WORDS-1
NOP_WORD, 32'h0000_0000, word placed in IF/ID on bubble/flush (sll $0,$0,0)

Ports:
clk  in  1  single clock, rising-edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID
flush  in  1  squash IF/ID contents (bubble) this edge
branch_taken  in  1  EX-resolved taken branch
branch_target  in  32  byte address of branch target
jump  in  1  ID-resolved j/jal/jr
jump_target  in  32  byte address of jump target
instr_in  in  32  Instr returned by instruction memory for pc_out
pc_out  out  32  current PC (byte address) to instruction memory
ifid_instr  out  32  registered instruction
ifid_pc_plus4  out  32  registered PC+4 of that instruction
ifid_valid  out  1  IF/ID holds a real instruction
fetch_fault  out  1  sticky: illegal fetch address requested
fetch_count  out  32  number of instructions accepted into IF/ID

Behaviour:
- Reset (async, rst=1) forces:
  - pc_out=RESET_PC, ifid_instr=NOP_WORD, ifid_pc_plus4=0, ifid_valid=0;
  - fetch_fault=0, fetch_count=0, state=RUN.
  - Reset asserted mid-operation discards everything immediately, with no edge needed.
  - First fetch after deassert is RESET_PC.
- States:
  - RUN: normal fetch.
  - HALT: entered on fault; only rst leaves it.
- next_pc selection in RUN, highest priority first:
  1. branch_taken -> branch_target
  2. jump -> jump_target
  3. stall -> pc_out (hold)
  4. otherwise pc_out+4
- Arithmetic: pc_out+4 is modulo 2^32, so wrap 32'hFFFF_FFFC -> 0. Wrap is then caught by the range check only if the result is out of range.
- Legality check is applied to next_pc on every RUN edge. Illegal if next_pc[1:0]!=0 or (next_pc>>2)>=IMEM_WORDS. On an illegal next_pc:
  - pc_out is not updated;
  - fetch_fault<=1 and state<=HALT;
  - IF/ID loads the bubble (NOP_WORD, valid=0).
  - RESET_PC itself is not checked.
- IF/ID update on each rising edge in RUN, first match wins:
  1. branch_taken or jump or flush -> bubble. The fetched word is on the wrong path, so redirect implies flush.
  2. stall -> IF/ID holds all fields.
  3. otherwise ifid_instr<=instr_in, ifid_pc_plus4<=pc_out+4, ifid_valid<=1.
- Simultaneous stall and redirect: redirect wins; PC loads target and IF/ID is bubbled.
- Simultaneous stall and flush without redirect: PC holds, IF/ID is bubbled.
- Latency:
  - Instruction at PC appears on ifid_* one edge after pc_out=PC.
  - A taken redirect costs exactly one bubble. Target is on pc_out the cycle after the redirect edge and in IF/ID one edge later.
- HALT: pc_out frozen, ifid_valid=0, ifid_instr=NOP_WORD, fetch_count frozen; all inputs ignored.
- fetch_count increments by 1 on each edge where IF/ID loads with ifid_valid<=1. It wraps modulo 2^32.
- No combinational path from any input to pc_out; all outputs are registered.

Test Plan:
1. Reset, then free run 4 cycles with memory words 0..3 = 0x11,0x22,0x33,0x44 -> pc_out 0,4,8,12. ifid_instr 0x11,0x22,0x33 with ifid_pc_plus4 4,8,12, ifid_valid=1, fetch_count=3.
2. Stall held 2 cycles at pc_out=8 -> pc_out stays 8, IF/ID holds 0x22/PC+4=8, fetch_count unchanged. On release, 0x33 loads next edge.
3. branch_taken=1 with branch_target=0x40 and stall=1 in the same cycle at pc_out=12 -> next pc_out=0x40, ifid_valid=0. The following edge gives ifid_instr=mem[16], ifid_pc_plus4=0x44.
4. jump=1 with jump_target=0x20 plus branch_taken=1 with branch_target=0x30 -> pc_out=0x30 (branch priority), exactly one bubble.
5. jump_target=0x192 (misaligned), then separately 0x190 (word 100, IMEM_WORDS=100) -> fetch_fault=1, pc_out unchanged, ifid_valid=0. Stays halted for 10 cycles despite inputs, and only rst clears it.
6. Assert rst asynchronously between edges while ifid_valid=1 and fetch_count=5 -> outputs go to reset values before the next clk edge. After release, the fetch restarts at RESET_PC.
